rom_port_arbiter: RTL

// - Shares the single read port of the instruction ROM (memoriaROM) between two requesters:
//   the instruction-fetch unit (IF) and the data-memory load path (DM, constant/literal reads).
// - Arbitrates per cycle, drives the ROM address, and returns registered read data to the winner.
// - Sits between the core's fetch/load stages and memoriaROM.
// - Read latency is one cycle, and a DM lock supports multi-word DM bursts.

---
 rtl/rom_arb_pkg.sv | 7 +
 rtl/rom_port_arbiter_if.sv | 30 +++
 rtl/rom_port_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM read-port arbiter.
//   arb_state_t : arbitration FSM state (who wins a tie, or DM-only while locked)
//   NOP_WORD    : word handed to fetch for out-of-range addresses (addi x0,x0,0)
package rom_arb_pkg;
  typedef enum logic [1:0] {ARB_IF, ARB_DM, ARB_DM_LOCKED} arb_state_t;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bundle between the fetch/load requesters, the arbiter and memoriaROM.
//   IF side : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   DM side : dm_req, dm_addr, dm_lock -> dm_gnt, dm_rvalid, dm_rdata
//   ROM side: rom_addr -> rom_data (combinational read)
// slave  = arbiter view; master = requesters plus the ROM itself.
interface rom_port_arbiter_if #(parameter int POS = 10);
  logic           if_req;
  logic [POS-1:0] if_addr;
  logic           if_gnt;
  logic           if_rvalid;
  logic [31:0]    if_rdata;
  logic           dm_req;
  logic [POS-1:0] dm_addr;
  logic           dm_lock;
  logic           dm_gnt;
  logic           dm_rvalid;
  logic [31:0]    dm_rdata;
  logic [POS-1:0] rom_addr;
  logic [31:0]    rom_data;

  modport slave (
    input  if_req, if_addr, dm_req, dm_addr, dm_lock, rom_data,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, rom_addr
  );

  modport master (
    output if_req, if_addr, dm_req, dm_addr, dm_lock, rom_data,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, rom_addr
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares memoriaROM's single read port between instruction fetch (IF) and
// the data-memory literal load path (DM). One grant per cycle, combinational
// grant, data registered one cycle later into the winner's RDATA with a
// one-cycle RVALID pulse. DM may lock the port across a multi-word burst.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rom_port_arbiter_if.slave (requests, grants, read data, ROM port)
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int POSICIONES = 1024,
  parameter int POS        = $clog2(POSICIONES)
) (
  input  logic                clk,
  input  logic                rst_n,
  rom_port_arbiter_if.slave   bus
);

  arb_state_t     state, next_state;
  logic           if_gnt, dm_gnt;
  logic [POS-1:0] rom_addr;
  logic [POS-1:0] addr_hold;
  logic           oob;
  logic           if_rvalid_q, dm_rvalid_q;
  logic [31:0]    if_rdata_q, dm_rdata_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IF;
    else        state <= next_state;
  end

  // Next state: the port just served loses the next tie; a locked DM keeps
  // ownership until it issues an unlocked read.
  always_comb begin
    next_state = state;
    if (if_gnt)      next_state = ARB_DM;
    else if (dm_gnt) next_state = bus.dm_lock ? ARB_DM_LOCKED : ARB_IF;
  end

  // Grants and ROM address mux
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    unique case (state)
      ARB_IF: begin
        if_gnt = bus.if_req;
        dm_gnt = bus.dm_req & ~bus.if_req;
      end
      ARB_DM: begin
        dm_gnt = bus.dm_req;
        if_gnt = bus.if_req & ~bus.dm_req;
      end
      ARB_DM_LOCKED: dm_gnt = bus.dm_req;
      default: ;
    endcase
    // Idle cycles replay the last address so the ROM address bus stays quiet.
    if (if_gnt)      rom_addr = bus.if_addr;
    else if (dm_gnt) rom_addr = bus.dm_addr;
    else             rom_addr = addr_hold;
  end

  // Depth need not be a power of two, so the upper part of the address space
  // is unbacked and must not return ROM garbage.
  assign oob = 32'(rom_addr) >= 32'(POSICIONES);

  // Address hold and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold   <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= if_gnt;
      dm_rvalid_q <= dm_gnt;
      if (if_gnt | dm_gnt) addr_hold <= rom_addr;
      if (if_gnt) if_rdata_q <= oob ? NOP_WORD : bus.rom_data;
      if (dm_gnt) dm_rdata_q <= oob ? 32'h0 : bus.rom_data;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.rom_addr  = rom_addr;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

endmodule
